// File: rtl/sub_bytes_sequencer.sv
// Round-level AES SubBytes engine: captures a 128-bit state, substitutes it
// BYTES_PER_CYCLE bytes per cycle, then holds the result for a downstream handshake.

module byte_substitution (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // FIPS-197 forward S-box as a constant ROM
  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h63;  8'h01: o_byte = 8'h7c;  8'h02: o_byte = 8'h77;  8'h03: o_byte = 8'h7b;
      8'h04: o_byte = 8'hf2;  8'h05: o_byte = 8'h6b;  8'h06: o_byte = 8'h6f;  8'h07: o_byte = 8'hc5;
      8'h08: o_byte = 8'h30;  8'h09: o_byte = 8'h01;  8'h0a: o_byte = 8'h67;  8'h0b: o_byte = 8'h2b;
      8'h0c: o_byte = 8'hfe;  8'h0d: o_byte = 8'hd7;  8'h0e: o_byte = 8'hab;  8'h0f: o_byte = 8'h76;
      8'h10: o_byte = 8'hca;  8'h11: o_byte = 8'h82;  8'h12: o_byte = 8'hc9;  8'h13: o_byte = 8'h7d;
      8'h14: o_byte = 8'hfa;  8'h15: o_byte = 8'h59;  8'h16: o_byte = 8'h47;  8'h17: o_byte = 8'hf0;
      8'h18: o_byte = 8'had;  8'h19: o_byte = 8'hd4;  8'h1a: o_byte = 8'ha2;  8'h1b: o_byte = 8'haf;
      8'h1c: o_byte = 8'h9c;  8'h1d: o_byte = 8'ha4;  8'h1e: o_byte = 8'h72;  8'h1f: o_byte = 8'hc0;
      8'h20: o_byte = 8'hb7;  8'h21: o_byte = 8'hfd;  8'h22: o_byte = 8'h93;  8'h23: o_byte = 8'h26;
      8'h24: o_byte = 8'h36;  8'h25: o_byte = 8'h3f;  8'h26: o_byte = 8'hf7;  8'h27: o_byte = 8'hcc;
      8'h28: o_byte = 8'h34;  8'h29: o_byte = 8'ha5;  8'h2a: o_byte = 8'he5;  8'h2b: o_byte = 8'hf1;
      8'h2c: o_byte = 8'h71;  8'h2d: o_byte = 8'hd8;  8'h2e: o_byte = 8'h31;  8'h2f: o_byte = 8'h15;
      8'h30: o_byte = 8'h04;  8'h31: o_byte = 8'hc7;  8'h32: o_byte = 8'h23;  8'h33: o_byte = 8'hc3;
      8'h34: o_byte = 8'h18;  8'h35: o_byte = 8'h96;  8'h36: o_byte = 8'h05;  8'h37: o_byte = 8'h9a;
      8'h38: o_byte = 8'h07;  8'h39: o_byte = 8'h12;  8'h3a: o_byte = 8'h80;  8'h3b: o_byte = 8'he2;
      8'h3c: o_byte = 8'heb;  8'h3d: o_byte = 8'h27;  8'h3e: o_byte = 8'hb2;  8'h3f: o_byte = 8'h75;
      8'h40: o_byte = 8'h09;  8'h41: o_byte = 8'h83;  8'h42: o_byte = 8'h2c;  8'h43: o_byte = 8'h1a;
      8'h44: o_byte = 8'h1b;  8'h45: o_byte = 8'h6e;  8'h46: o_byte = 8'h5a;  8'h47: o_byte = 8'ha0;
      8'h48: o_byte = 8'h52;  8'h49: o_byte = 8'h3b;  8'h4a: o_byte = 8'hd6;  8'h4b: o_byte = 8'hb3;
      8'h4c: o_byte = 8'h29;  8'h4d: o_byte = 8'he3;  8'h4e: o_byte = 8'h2f;  8'h4f: o_byte = 8'h84;
      8'h50: o_byte = 8'h53;  8'h51: o_byte = 8'hd1;  8'h52: o_byte = 8'h00;  8'h53: o_byte = 8'hed;
      8'h54: o_byte = 8'h20;  8'h55: o_byte = 8'hfc;  8'h56: o_byte = 8'hb1;  8'h57: o_byte = 8'h5b;
      8'h58: o_byte = 8'h6a;  8'h59: o_byte = 8'hcb;  8'h5a: o_byte = 8'hbe;  8'h5b: o_byte = 8'h39;
      8'h5c: o_byte = 8'h4a;  8'h5d: o_byte = 8'h4c;  8'h5e: o_byte = 8'h58;  8'h5f: o_byte = 8'hcf;
      8'h60: o_byte = 8'hd0;  8'h61: o_byte = 8'hef;  8'h62: o_byte = 8'haa;  8'h63: o_byte = 8'hfb;
      8'h64: o_byte = 8'h43;  8'h65: o_byte = 8'h4d;  8'h66: o_byte = 8'h33;  8'h67: o_byte = 8'h85;
      8'h68: o_byte = 8'h45;  8'h69: o_byte = 8'hf9;  8'h6a: o_byte = 8'h02;  8'h6b: o_byte = 8'h7f;
      8'h6c: o_byte = 8'h50;  8'h6d: o_byte = 8'h3c;  8'h6e: o_byte = 8'h9f;  8'h6f: o_byte = 8'ha8;
      8'h70: o_byte = 8'h51;  8'h71: o_byte = 8'ha3;  8'h72: o_byte = 8'h40;  8'h73: o_byte = 8'h8f;
      8'h74: o_byte = 8'h92;  8'h75: o_byte = 8'h9d;  8'h76: o_byte = 8'h38;  8'h77: o_byte = 8'hf5;
      8'h78: o_byte = 8'hbc;  8'h79: o_byte = 8'hb6;  8'h7a: o_byte = 8'hda;  8'h7b: o_byte = 8'h21;
      8'h7c: o_byte = 8'h10;  8'h7d: o_byte = 8'hff;  8'h7e: o_byte = 8'hf3;  8'h7f: o_byte = 8'hd2;
      8'h80: o_byte = 8'hcd;  8'h81: o_byte = 8'h0c;  8'h82: o_byte = 8'h13;  8'h83: o_byte = 8'hec;
      8'h84: o_byte = 8'h5f;  8'h85: o_byte = 8'h97;  8'h86: o_byte = 8'h44;  8'h87: o_byte = 8'h17;
      8'h88: o_byte = 8'hc4;  8'h89: o_byte = 8'ha7;  8'h8a: o_byte = 8'h7e;  8'h8b: o_byte = 8'h3d;
      8'h8c: o_byte = 8'h64;  8'h8d: o_byte = 8'h5d;  8'h8e: o_byte = 8'h19;  8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h60;  8'h91: o_byte = 8'h81;  8'h92: o_byte = 8'h4f;  8'h93: o_byte = 8'hdc;
      8'h94: o_byte = 8'h22;  8'h95: o_byte = 8'h2a;  8'h96: o_byte = 8'h90;  8'h97: o_byte = 8'h88;
      8'h98: o_byte = 8'h46;  8'h99: o_byte = 8'hee;  8'h9a: o_byte = 8'hb8;  8'h9b: o_byte = 8'h14;
      8'h9c: o_byte = 8'hde;  8'h9d: o_byte = 8'h5e;  8'h9e: o_byte = 8'h0b;  8'h9f: o_byte = 8'hdb;
      8'ha0: o_byte = 8'he0;  8'ha1: o_byte = 8'h32;  8'ha2: o_byte = 8'h3a;  8'ha3: o_byte = 8'h0a;
      8'ha4: o_byte = 8'h49;  8'ha5: o_byte = 8'h06;  8'ha6: o_byte = 8'h24;  8'ha7: o_byte = 8'h5c;
      8'ha8: o_byte = 8'hc2;  8'ha9: o_byte = 8'hd3;  8'haa: o_byte = 8'hac;  8'hab: o_byte = 8'h62;
      8'hac: o_byte = 8'h91;  8'had: o_byte = 8'h95;  8'hae: o_byte = 8'he4;  8'haf: o_byte = 8'h79;
      8'hb0: o_byte = 8'he7;  8'hb1: o_byte = 8'hc8;  8'hb2: o_byte = 8'h37;  8'hb3: o_byte = 8'h6d;
      8'hb4: o_byte = 8'h8d;  8'hb5: o_byte = 8'hd5;  8'hb6: o_byte = 8'h4e;  8'hb7: o_byte = 8'ha9;
      8'hb8: o_byte = 8'h6c;  8'hb9: o_byte = 8'h56;  8'hba: o_byte = 8'hf4;  8'hbb: o_byte = 8'hea;
      8'hbc: o_byte = 8'h65;  8'hbd: o_byte = 8'h7a;  8'hbe: o_byte = 8'hae;  8'hbf: o_byte = 8'h08;
      8'hc0: o_byte = 8'hba;  8'hc1: o_byte = 8'h78;  8'hc2: o_byte = 8'h25;  8'hc3: o_byte = 8'h2e;
      8'hc4: o_byte = 8'h1c;  8'hc5: o_byte = 8'ha6;  8'hc6: o_byte = 8'hb4;  8'hc7: o_byte = 8'hc6;
      8'hc8: o_byte = 8'he8;  8'hc9: o_byte = 8'hdd;  8'hca: o_byte = 8'h74;  8'hcb: o_byte = 8'h1f;
      8'hcc: o_byte = 8'h4b;  8'hcd: o_byte = 8'hbd;  8'hce: o_byte = 8'h8b;  8'hcf: o_byte = 8'h8a;
      8'hd0: o_byte = 8'h70;  8'hd1: o_byte = 8'h3e;  8'hd2: o_byte = 8'hb5;  8'hd3: o_byte = 8'h66;
      8'hd4: o_byte = 8'h48;  8'hd5: o_byte = 8'h03;  8'hd6: o_byte = 8'hf6;  8'hd7: o_byte = 8'h0e;
      8'hd8: o_byte = 8'h61;  8'hd9: o_byte = 8'h35;  8'hda: o_byte = 8'h57;  8'hdb: o_byte = 8'hb9;
      8'hdc: o_byte = 8'h86;  8'hdd: o_byte = 8'hc1;  8'hde: o_byte = 8'h1d;  8'hdf: o_byte = 8'h9e;
      8'he0: o_byte = 8'he1;  8'he1: o_byte = 8'hf8;  8'he2: o_byte = 8'h98;  8'he3: o_byte = 8'h11;
      8'he4: o_byte = 8'h69;  8'he5: o_byte = 8'hd9;  8'he6: o_byte = 8'h8e;  8'he7: o_byte = 8'h94;
      8'he8: o_byte = 8'h9b;  8'he9: o_byte = 8'h1e;  8'hea: o_byte = 8'h87;  8'heb: o_byte = 8'he9;
      8'hec: o_byte = 8'hce;  8'hed: o_byte = 8'h55;  8'hee: o_byte = 8'h28;  8'hef: o_byte = 8'hdf;
      8'hf0: o_byte = 8'h8c;  8'hf1: o_byte = 8'ha1;  8'hf2: o_byte = 8'h89;  8'hf3: o_byte = 8'h0d;
      8'hf4: o_byte = 8'hbf;  8'hf5: o_byte = 8'he6;  8'hf6: o_byte = 8'h42;  8'hf7: o_byte = 8'h68;
      8'hf8: o_byte = 8'h41;  8'hf9: o_byte = 8'h99;  8'hfa: o_byte = 8'h2d;  8'hfb: o_byte = 8'h0f;
      8'hfc: o_byte = 8'hb0;  8'hfd: o_byte = 8'h54;  8'hfe: o_byte = 8'hbb;  8'hff: o_byte = 8'h16;
      default: o_byte = 8'h00;
    endcase
  end

endmodule

module sub_bytes_sequencer #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NCHUNK    = 16 / BYTES_PER_CYCLE;
  localparam int LANE_W    = 8 * BYTES_PER_CYCLE;
  localparam int LOG_LANE  = $clog2(LANE_W);
  localparam int TOP_SHIFT = 128 - LANE_W;
  localparam int CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NCHUNK - 1);
  localparam logic [127:0]     LANE_MASK = {128{1'b1}} << TOP_SHIFT;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [127:0]     r_captured;
  logic [127:0]     r_out_state;
  logic             r_out_valid;

  logic              w_accept;
  logic [7:0]        w_shamt;
  logic [LANE_W-1:0] w_chunk_in;
  logic [LANE_W-1:0] w_chunk_out;
  logic [127:0]      w_fill;
  logic [127:0]      w_mask;

  assign in_ready  = rst_n & ~clear & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_state = r_out_state;
  assign busy      = (r_state == ST_BUSY);

  // Chunk cnt occupies the bit window starting cnt*LANE_W bits below the MSB
  assign w_shamt    = 8'(r_cnt) << LOG_LANE;
  assign w_chunk_in = LANE_W'((r_captured << w_shamt) >> TOP_SHIFT);
  assign w_fill     = ((128'(w_chunk_out)) << TOP_SHIFT) >> w_shamt;
  assign w_mask     = LANE_MASK >> w_shamt;

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    byte_substitution u_sbox (
      .i_byte (w_chunk_in[LANE_W-1-8*g -: 8]),
      .o_byte (w_chunk_out[LANE_W-1-8*g -: 8])
    );
  end

  // Block sequencing: capture, chunked substitution, output hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_captured  <= 128'h0;
      r_out_state <= 128'h0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_captured <= in_state;
            r_cnt      <= '0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_out_state <= (r_out_state & ~w_mask) | w_fill;
          if (r_cnt == LAST_CNT) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_captured <= in_state;
              r_cnt      <= '0;
              r_state    <= ST_BUSY;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// Self-checking bench for sub_bytes_sequencer: block-level reference model with
// a per-cycle compare process, plus directed FIPS-197 and handshake scenarios.

module tb_sub_bytes_sequencer;

  localparam logic [127:0] V_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] R0_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R0_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] ALL63 = {16{8'h63}};
  localparam logic [127:0] ALL16 = {16{8'h16}};
  localparam logic [127:0] ALLFF = {16{8'hff}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = 128'h0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

  logic [3:0]   sw_in_valid = 4'h0;
  logic [3:0]   sw_in_ready;
  logic [3:0]   sw_out_valid;
  logic [3:0]   sw_busy;
  logic [127:0] sw_out_state [4];
  logic         sw_out_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_bytes_sequencer #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy));

  sub_bytes_sequencer #(.BYTES_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
    .in_state(in_state), .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready),
    .out_state(sw_out_state[0]), .busy(sw_busy[0]));
  sub_bytes_sequencer #(.BYTES_PER_CYCLE(2)) u_b2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
    .in_state(in_state), .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready),
    .out_state(sw_out_state[1]), .busy(sw_busy[1]));
  sub_bytes_sequencer #(.BYTES_PER_CYCLE(8)) u_b8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
    .in_state(in_state), .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready),
    .out_state(sw_out_state[2]), .busy(sw_busy[2]));
  sub_bytes_sequencer #(.BYTES_PER_CYCLE(16)) u_b16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(sw_in_valid[3]), .in_ready(sw_in_ready[3]),
    .in_state(in_state), .out_valid(sw_out_valid[3]), .out_ready(sw_out_ready),
    .out_state(sw_out_state[3]), .busy(sw_busy[3]));

  // S-box derived from GF(2^8) arithmetic: inverse as a^254, then the affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] s);
    logic [127:0] r = 128'h0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_ref(s[127-8*i -: 8]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Block-level model: a block accepted at some edge appears NCHUNK edges later
  localparam int NCHUNK_MAIN = 4;
  logic         m_pending = 1'b0;
  logic         m_out_valid = 1'b0;
  int           m_left = 0;
  logic [127:0] m_block = 128'h0;
  logic [127:0] m_out = 128'h0;
  int           cyc = 0;
  int           acc_log[$];
  int           hs_log[$];
  logic [127:0] hs_val[$];

  function automatic logic m_ready();
    return rst_n && !clear && !m_pending && (!m_out_valid || out_ready);
  endfunction

  initial forever begin
    logic acc;
    logic hs;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pending   = 1'b0;
      m_out_valid = 1'b0;
      m_left      = 0;
    end else begin
      cyc++;
      if (in_valid && in_ready) acc_log.push_back(cyc);
      if (out_valid && out_ready && !clear) begin
        hs_log.push_back(cyc);
        hs_val.push_back(out_state);
      end
      acc = in_valid && m_ready();
      hs  = m_out_valid && out_ready && !clear;
      if (clear) begin
        m_pending   = 1'b0;
        m_out_valid = 1'b0;
      end else begin
        if (hs) m_out_valid = 1'b0;
        if (m_pending) begin
          m_left--;
          if (m_left == 0) begin
            m_pending   = 1'b0;
            m_out_valid = 1'b1;
            m_out       = sub128(m_block);
          end
        end
        if (acc) begin
          m_pending = 1'b1;
          m_left    = NCHUNK_MAIN;
          m_block   = in_state;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chki("cyc_in_ready", int'(in_ready), int'(m_ready()));
    chki("cyc_out_valid", int'(out_valid), int'(m_out_valid));
    chki("cyc_busy", int'(busy), int'(m_pending));
    if (m_out_valid) chk("cyc_out_state", out_state, m_out);
  end

  task automatic send(input logic [127:0] blk);
    int budget = 0;
    in_state = blk;
    in_valid = 1'b1;
    #1;
    while (!in_ready && budget < 50) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (!in_ready) chki("accept_timeout", int'(in_ready), 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int bcyc);
    lat  = 0;
    bcyc = int'(busy);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
      if (busy) bcyc++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int sw_lat [4];
    logic [127:0] sw_got [4];
    int exp_lat [4] = '{16, 8, 2, 1};

    // Model pins: hand-computed S-box results
    chk("model_fips", sub128(V_IN), V_OUT);
    chk("model_row0", sub128(R0_IN), R0_OUT);
    chk("model_zero", sub128(128'h0), ALL63);

    // Power-on reset
    #2;
    chki("por_out_valid", int'(out_valid), 0);
    chki("por_busy", int'(busy), 0);
    chk("por_out_state", out_state, 128'h0);
    chki("por_in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chki("idle_in_ready", int'(in_ready), 1);

    // FIPS-197 vector, out_ready held high
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    send(V_IN);
    wait_out(lat, bc);
    chki("fips_latency", lat, 4);
    chki("fips_busy_cycles", bc, 4);
    chk("fips_out_state", out_state, V_OUT);

    // Backpressure hold, with a rejected second request
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send(128'h0);
    wait_out(lat, bc);
    chki("bp_latency", lat, 4);
    in_state = R0_IN;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chki("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_state", out_state, ALL63);
      chki("bp_hold_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chki("bp_release_ready", int'(in_ready), 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    wait_out(lat, bc);
    chki("bp_second_latency", lat, 4);
    chk("bp_second_state", out_state, R0_OUT);

    // Back-to-back blocks with the handoff overlapping the first output
    @(posedge clk);
    #2;
    acc_log.delete();
    hs_log.delete();
    hs_val.delete();
    in_state = ALLFF;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      if (acc_log.size() == 1) in_state = 128'h0;
      if (acc_log.size() >= 2) break;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 30 && hs_log.size() < 2; i++) @(posedge clk);
    #2;
    chki("b2b_accepts", acc_log.size(), 2);
    chki("b2b_outputs", hs_log.size(), 2);
    if (acc_log.size() >= 2 && hs_log.size() >= 2) begin
      chki("b2b_spacing", acc_log[1] - acc_log[0], 5);
      chki("b2b_overlap", acc_log[1], hs_log[0]);
      chk("b2b_first", hs_val[0], ALL16);
      chk("b2b_second", hs_val[1], ALL63);
    end

    // Clear during chunk 2 drops the block and blocks a same-cycle request
    @(posedge clk);
    #2;
    send(V_IN);
    repeat (2) @(posedge clk);
    #2;
    clear = 1'b1;
    in_state = 128'h0;
    in_valid = 1'b1;
    #1;
    chki("clr_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #2;
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    chki("clr_busy", int'(busy), 0);
    chki("clr_idle_ready", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chki("clr_no_output", int'(out_valid), 0);
    end
    #1;
    send(128'h0);
    wait_out(lat, bc);
    chki("clr_next_latency", lat, 4);
    chk("clr_next_state", out_state, ALL63);

    // Asynchronous reset while holding a result in DONE
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send(V_IN);
    wait_out(lat, bc);
    #1;
    rst_n = 1'b0;
    #1;
    chki("rst_done_valid", int'(out_valid), 0);
    chki("rst_done_busy", int'(busy), 0);
    chk("rst_done_state", out_state, 128'h0);
    chki("rst_done_ready", int'(in_ready), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Asynchronous reset mid-BUSY
    @(posedge clk);
    #2;
    send(V_IN);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chki("rst_busy_busy", int'(busy), 0);
    chk("rst_busy_state", out_state, 128'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chki("rst_no_output", int'(out_valid), 0);
    end

    // Parameter sweep on the same vector
    @(posedge clk);
    #2;
    in_state = V_IN;
    sw_in_valid = 4'hf;
    #1;
    chki("sw_in_ready", int'(sw_in_ready), 15);
    @(posedge clk);
    #2;
    sw_in_valid = 4'h0;
    for (int i = 0; i < 4; i++) begin
      sw_lat[i] = 0;
      sw_got[i] = 128'h0;
    end
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (sw_out_valid[i] && sw_lat[i] == 0) begin
          sw_lat[i] = k;
          sw_got[i] = sw_out_state[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chki($sformatf("sw%0d_latency", i), sw_lat[i], exp_lat[i]);
      chk($sformatf("sw%0d_state", i), sw_got[i], V_OUT);
    end
    chki("sw_idle_busy", int'(sw_busy), 0);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
